// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: inter-stage bus widths, reset PC, fetch FSM encoding
// and the field layout of the decode-to-fetch redirect bus.
package if_stage_pkg;

  localparam int IF_ID_LEN  = 64;
  localparam int BR_BUS_LEN = 33;
  localparam int ID_EX_LEN  = 150;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  localparam int BR_TAKEN_BIT  = 32;
  localparam int BR_TARGET_MSB = 31;
  localparam int BR_TARGET_LSB = 0;

  typedef enum logic {
    FS_REQ  = 1'b0,
    FS_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// LoongArch32 fetch stage: single-outstanding SRAM-like instruction fetch with a
// one-entry buffer toward decode and cancellation of wrong-path responses.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = if_stage_pkg::RESET_PC,
  parameter int          IF_ID_LEN = if_stage_pkg::IF_ID_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  inst_sram_req,
  output logic                  inst_sram_wr,
  output logic [1:0]            inst_sram_size,
  output logic [3:0]            inst_sram_wstrb,
  output logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_wdata,
  input  logic                  inst_sram_addr_ok,
  input  logic                  inst_sram_data_ok,
  input  logic [31:0]           inst_sram_rdata,
  input  logic [BR_BUS_LEN-1:0] br_bus,
  input  logic                  ID_allowin,
  output logic                  IF_ID_valid,
  output logic [IF_ID_LEN-1:0]  IF_ID_bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  br_pc_q, br_pc_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic         buf_valid_q, buf_valid_d;
  logic         cancel_q, cancel_d;

  logic         br_taken;
  logic [31:0]  br_target;
  logic         drain;
  logic         req;
  logic         accept;
  logic         fill;

  assign br_taken  = br_bus[BR_TAKEN_BIT];
  assign br_target = br_bus[BR_TARGET_MSB:BR_TARGET_LSB];

  // A request may go out when the buffer is empty or is being drained this cycle,
  // so the refill never overwrites an instruction decode has not taken yet.
  assign drain  = buf_valid_q & ID_allowin;
  assign req    = ~reset & (state_q == FS_REQ) & (~buf_valid_q | drain);
  assign accept = req & inst_sram_addr_ok;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    br_pc_d     = br_pc_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    cancel_d    = cancel_q;
    fill        = 1'b0;
    case (state_q)
      FS_REQ: begin
        if (accept) begin
          state_d = FS_WAIT;
          if (br_taken) begin
            cancel_d = 1'b1;
            br_pc_d  = br_target;
          end
        end else if (br_taken) begin
          pc_d = br_target;
        end
      end
      FS_WAIT: begin
        if (inst_sram_data_ok) begin
          state_d  = FS_REQ;
          cancel_d = 1'b0;
          if (br_taken) begin
            pc_d = br_target;
          end else if (cancel_q) begin
            pc_d = br_pc_q;
          end else begin
            buf_inst_d = inst_sram_rdata;
            buf_pc_d   = pc_q;
            fill       = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end else if (br_taken) begin
          // Latest redirect wins if several arrive while the response is pending.
          cancel_d = 1'b1;
          br_pc_d  = br_target;
        end
      end
      default: state_d = FS_REQ;
    endcase

    if (br_taken) begin
      buf_valid_d = 1'b0;
    end else if (fill) begin
      buf_valid_d = 1'b1;
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FS_REQ;
      pc_q        <= RESET_PC;
      br_pc_q     <= 32'd0;
      buf_inst_q  <= 32'd0;
      buf_pc_q    <= 32'd0;
      buf_valid_q <= 1'b0;
      cancel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      br_pc_q     <= br_pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      cancel_q    <= cancel_d;
    end
  end

  assign inst_sram_req   = req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'd0;

  assign IF_ID_valid = buf_valid_q;
  assign IF_ID_bus   = {buf_inst_q, buf_pc_q};

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/redirect/reset scenarios plus a randomized
// run checked against an instruction-stream model of what decode should receive.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'd0;
  logic [32:0] br_bus = 33'd0;
  logic        ID_allowin = 1'b0;
  logic        IF_ID_valid;
  logic [63:0] IF_ID_bus;

  if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .br_bus            (br_bus),
    .ID_allowin        (ID_allowin),
    .IF_ID_valid       (IF_ID_valid),
    .IF_ID_bus         (IF_ID_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory-side model: at most one accepted request awaiting its response.
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;

  logic        o_req, o_valid, o_aok, o_dok;
  logic [31:0] o_addr;
  logic [63:0] o_bus;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h1234_5678;
  endfunction

  task automatic cycle(input bit allow, input bit brt, input logic [31:0] tgt,
                       input bit aok_en, input bit dok_en);
    @(negedge clk);
    ID_allowin = allow;
    br_bus     = {brt, tgt};
    #1;
    o_req   = inst_sram_req;
    o_addr  = inst_sram_addr;
    o_valid = IF_ID_valid;
    o_bus   = IF_ID_bus;
    o_aok   = o_req & aok_en & ~pend;
    o_dok   = pend & dok_en;
    inst_sram_addr_ok = o_aok;
    inst_sram_data_ok = o_dok;
    inst_sram_rdata   = o_dok ? memf(pend_addr) : 32'hdead_beef;
    @(posedge clk);
    if (o_aok) begin
      pend      = 1'b1;
      pend_addr = o_addr;
    end else if (o_dok) begin
      pend = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ID_allowin = 1'b0;
    br_bus = 33'd0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'd0;
    pend = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ID_allowin = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (inst_sram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b expected 0", inst_sram_req); end
    checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", IF_ID_valid); end
    checks++; if (IF_ID_bus !== 64'd0) begin failures++; $display("FAIL reset_bus: got %h expected 0", IF_ID_bus); end
    reset = 1'b0;
    #1;
    checks++; if (inst_sram_req !== 1'b1) begin failures++; $display("FAIL reset_first_req: got %0b expected 1", inst_sram_req); end
    checks++; if (inst_sram_addr !== RPC) begin failures++; $display("FAIL reset_first_addr: got %h expected %h", inst_sram_addr, RPC); end
    checks++; if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'd0, 32'd0}) begin
      failures++; $display("FAIL const_outputs: got %0b/%0b/%h/%h expected 0/10/0/0", inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      checks++; if (o_req !== 1'((k % 2) == 0)) begin failures++; $display("FAIL stream_req[%0d]: got %0b expected %0b", k, o_req, (k % 2) == 0); end
      checks++; if (o_valid !== 1'(k >= 2 && (k % 2) == 0)) begin failures++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", k, o_valid, (k >= 2 && (k % 2) == 0)); end
      if ((k % 2) == 0) begin
        a = RPC + 32'(4 * (k / 2));
        checks++; if (o_addr !== a) begin failures++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, o_addr, a); end
      end
      if (k >= 2 && (k % 2) == 0) begin
        a = RPC + 32'(4 * (k / 2 - 1));
        checks++; if (o_bus !== {memf(a), a}) begin failures++; $display("FAIL stream_bus[%0d]: got %h expected %h", k, o_bus, {memf(a), a}); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL stall_req[%0d]: got %0b expected 0", k, o_req); end
      checks++; if (o_valid !== 1'b1 || o_bus !== {memf(RPC), RPC}) begin
        failures++; $display("FAIL stall_bus[%0d]: got %0b/%h expected 1/%h", k, o_valid, o_bus, {memf(RPC), RPC});
      end
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL stall_release_valid: got %0b expected 1", o_valid); end
    checks++; if (o_req !== 1'b1 || o_addr !== RPC + 32'd4) begin
      failures++; $display("FAIL stall_release_req: got %0b/%h expected 1/%h", o_req, o_addr, RPC + 32'd4);
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stall_after_handoff: got %0b expected 0", o_valid); end
  endtask

  task automatic test_br_req();
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h1c00_0100, 1'b0, 1'b1);
    checks++; if (o_req !== 1'b1 || o_addr !== RPC + 32'd4) begin
      failures++; $display("FAIL brreq_pre: got %0b/%h expected 1/%h", o_req, o_addr, RPC + 32'd4);
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL brreq_drop: got %0b expected 0", o_valid); end
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h1c00_0100) begin
      failures++; $display("FAIL brreq_retarget: got %0b/%h expected 1/1c000100", o_req, o_addr);
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_bus !== {memf(32'h1c00_0100), 32'h1c00_0100}) begin
      failures++; $display("FAIL brreq_deliver: got %0b/%h expected 1/%h", o_valid, o_bus, {memf(32'h1c00_0100), 32'h1c00_0100});
    end
  endtask

  task automatic test_br_wait();
    do_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h1c00_0200, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b1, k == 2);
      checks++; if (o_valid !== 1'b0 || o_req !== 1'b0) begin
        failures++; $display("FAIL brwait_idle[%0d]: got valid=%0b req=%0b expected 0/0", k, o_valid, o_req);
      end
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL brwait_discard: got %0b expected 0", o_valid); end
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h1c00_0200) begin
      failures++; $display("FAIL brwait_addr: got %0b/%h expected 1/1c000200", o_req, o_addr);
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_bus !== {memf(32'h1c00_0200), 32'h1c00_0200}) begin
      failures++; $display("FAIL brwait_deliver: got %0b/%h expected 1/%h", o_valid, o_bus, {memf(32'h1c00_0200), 32'h1c00_0200});
    end
  endtask

  task automatic test_double_br();
    do_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h1c00_0300, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h1c00_0400, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL dbl_discard: got %0b expected 0", o_valid); end
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h1c00_0400) begin
      failures++; $display("FAIL dbl_addr: got %0b/%h expected 1/1c000400", o_req, o_addr);
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++; if (o_valid !== 1'b1 || o_bus !== {memf(32'h1c00_0400), 32'h1c00_0400}) begin
      failures++; $display("FAIL dbl_deliver: got %0b/%h expected 1/%h", o_valid, o_bus, {memf(32'h1c00_0400), 32'h1c00_0400});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (inst_sram_req !== 1'b0 || IF_ID_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctrl: got req=%0b valid=%0b expected 0/0", inst_sram_req, IF_ID_valid);
    end
    checks++; if (IF_ID_bus !== 64'd0) begin failures++; $display("FAIL rstmid_bus: got %h expected 0", IF_ID_bus); end
    pend = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'hbad0_0bad;
    @(negedge clk);
    inst_sram_data_ok = 1'b0;
    #1;
    checks++; if (IF_ID_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale_data: got %0b expected 0", IF_ID_valid); end
    checks++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin
      failures++; $display("FAIL rstmid_first_addr: got %0b/%h expected 1/%h", inst_sram_req, inst_sram_addr, RPC);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, tgt, prev_addr;
    bit allow, brt, aok, dok, was_pend, prev_req, prev_aok, prev_brt;
    int delivered;
    do_reset();
    exp_pc = RPC;
    delivered = 0;
    prev_req = 1'b0; prev_aok = 1'b0; prev_brt = 1'b0; prev_addr = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      allow = ($urandom % 4) != 0;
      brt   = ($urandom % 16) == 0;
      tgt   = (($urandom % 8) == 0) ? 32'hffff_fff8 : RPC + 32'(($urandom % 64) * 4);
      aok   = ($urandom % 3) != 0;
      dok   = ($urandom % 3) != 0;
      was_pend = pend;
      cycle(allow, brt, tgt, aok, dok);
      if (was_pend) begin
        checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL rnd_outstanding[%0d]: got req=%0b expected 0", n, o_req); end
      end
      if (prev_req && !prev_aok && !prev_brt) begin
        checks++; if (o_req !== 1'b1 || o_addr !== prev_addr) begin
          failures++; $display("FAIL rnd_req_hold[%0d]: got %0b/%h expected 1/%h", n, o_req, o_addr, prev_addr);
        end
      end
      if (o_valid && allow && !brt) begin
        checks++; if (o_bus !== {memf(exp_pc), exp_pc}) begin
          failures++; $display("FAIL rnd_deliver[%0d]: got %h expected %h", n, o_bus, {memf(exp_pc), exp_pc});
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (brt) exp_pc = tgt;
      prev_req = o_req; prev_aok = o_aok; prev_addr = o_addr; prev_brt = brt;
    end
    checks++; if (delivered < 100) begin failures++; $display("FAIL rnd_progress: got %0d deliveries expected >= 100", delivered); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_br_req();
    test_br_wait();
    test_double_br();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Fetch stage of the 5-stage LoongArch32 pipeline. It drives the instruction SRAM-like port (req/addr_ok/data_ok) and delivers {inst, pc} to the decode stage over IF_ID_valid/ID_allowin. It consumes the decode stage's br_bus redirect and discards wrong-path fetches, including requests already accepted by memory. One request is outstanding at most, backed by a one-entry instruction buffer.

Parameters:
RESET_PC, 32'h1c00_0000, first fetch address after reset
IF_ID_LEN, 64, IF_ID bus width {inst[31:0], pc[31:0]}

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
inst_sram_req  out  1  fetch request
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10 (word)
inst_sram_wstrb  out  4  constant 0
inst_sram_addr  out  32  fetch address (= pc register)
inst_sram_wdata  out  32  constant 0
inst_sram_addr_ok  in  1  request accepted this cycle
inst_sram_data_ok  in  1  read data valid this cycle
inst_sram_rdata  in  32  fetched instruction
br_bus  in  33  {br_taken, br_target}; br_taken is a one-cycle pulse from decode
ID_allowin  in  1  decode can accept this cycle
IF_ID_valid  out  1  buf_valid
IF_ID_bus  out  IF_ID_LEN  {buf_inst, buf_pc}

Behaviour:
- Reset (async): state=REQ, pc=RESET_PC, buf_valid=0, buf_inst/buf_pc=0, cancel=0, br_pc=0. Outputs while reset is high: req=0, IF_ID_valid=0, IF_ID_bus=0.
- State REQ: req=1 when ~buf_valid or (IF_ID_valid & ID_allowin) this cycle; otherwise req=0.
  - req & addr_ok -> WAIT.
  - Once req is raised, it stays high until addr_ok, unless a branch changes addr.
- State WAIT: req=0.
  - On data_ok with cancel=0: buf_inst<=rdata, buf_pc<=pc, buf_valid<=1, pc<=pc+4, -> REQ.
  - On data_ok with cancel=1: data dropped, pc<=br_pc, cancel<=0, -> REQ.
- Handoff: IF_ID_valid & ID_allowin & ~br_taken clears buf_valid, unless the buffer is refilled in the same cycle.
- Best case throughput with a zero-wait SRAM: one instruction per 2 cycles.
- Redirect (br_taken=1). In every case buf_valid<=0 the same cycle; a concurrent handshake is void because decode drops its input on br_taken.
  - REQ, no addr_ok: pc<=br_target. The unaccepted request is retargeted.
  - REQ with addr_ok: cancel<=1, br_pc<=br_target, -> WAIT.
  - WAIT, no data_ok: cancel<=1, br_pc<=br_target. If already cancelling, the newest target wins.
  - WAIT with data_ok: rdata dropped, pc<=br_target, cancel<=0, -> REQ.
- Arithmetic: pc+4 wraps modulo 2^32. Targets pass through unaligned; alignment exceptions are not detected here.
- The block never issues a second request before data_ok of the first.
- Reset mid-transaction: state is cleared immediately. A data_ok arriving after reset release while in REQ is ignored; the SRAM side is reset together.

Decomposition:
- Shared pipeline package holds:
  - IF_ID_LEN=64, BR_BUS_LEN=33, ID_EX_LEN
  - RESET_PC
  - the fetch state encoding (REQ, WAIT)
  - br_bus field offsets (taken=bit 32, target=31:0)
- No sub-module: FSM, pc, buffer and cancel logic live in one module.

Test Plan:
- Reset release, zero-wait SRAM, ID_allowin=1 -> addrs 1c000000, 1c000004, 1c000008 on successive req/addr_ok; IF_ID_bus={rdata, pc} each; IF_ID_valid every 2nd cycle.
- ID_allowin=0 for 5 cycles with buffer full -> req stays 0, IF_ID_bus stable. Raise ID_allowin -> handoff, then req for pc+4 in the same cycle.
- br_taken target=1c000100 while REQ and addr_ok=0 -> next cycle addr=1c000100, no cancel, buffered inst dropped (IF_ID_valid=0).
- br_taken target=1c000200 in WAIT, data_ok delayed 3 cycles -> that data is discarded (IF_ID_valid stays 0), next req addr=1c000200.
- Two br_taken pulses (1c000300, then 1c000400) during one WAIT -> single discard, next fetch at 1c000400.
- Assert reset during WAIT -> req=0 and IF_ID_valid=0 immediately; after release, first addr=1c000000.
